// File: rtl/bus_device_port.sv
// Device-side endpoint for the bus arbiter: a TX FIFO feeding pndng/pop/D_pop,
// an ID-filtered RX FIFO fed by push/D_push, and sticky protocol-error flags.

module bus_device_port_fifo #(
    parameter int W     = 24,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr,
    input  logic [W-1:0]  wdata,
    input  logic          rd,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    // Power-of-two depth lets the pointers wrap through natural overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr) wptr <= wptr + 1'b1;
            if (rd) rptr <= rptr + 1'b1;
            if (wr && !rd)
                count <= count + 1'b1;
            else if (!wr && rd)
                count <= count - 1'b1;
        end
    end

    // Storage is not reset; stale entries are hidden by the zero-forced head.
    always_ff @(posedge clk) begin
        if (!reset && wr)
            mem[wptr] <= wdata;
    end

    assign head = (count != '0) ? mem[rptr] : '0;
endmodule

module bus_device_port #(
    parameter int         PCKG_SZ = 24,
    parameter int         DEPTH   = 8,
    parameter logic [7:0] DEV_ID  = 8'h00,
    parameter int         CW      = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tx_valid,
    input  logic [PCKG_SZ-1:0] tx_data,
    output logic               tx_ready,
    output logic               rx_valid,
    output logic [PCKG_SZ-1:0] rx_data,
    input  logic               rx_ready,
    output logic               pndng,
    output logic [PCKG_SZ-1:0] D_pop,
    input  logic               pop,
    input  logic               push,
    input  logic [PCKG_SZ-1:0] D_push,
    output logic [CW-1:0]      tx_count,
    output logic [CW-1:0]      rx_count,
    output logic               rx_overflow,
    output logic               rx_misroute,
    output logic               pop_underflow
);
    localparam logic [7:0] BCAST = 8'hFF;

    logic tx_wr, tx_rd;
    logic rx_wr, rx_rd;
    logic rx_full;
    logic id_ok;

    // Handshake outputs come only from registered counts.
    assign tx_ready = (tx_count != CW'(DEPTH));
    assign pndng    = (tx_count != '0);
    assign rx_valid = (rx_count != '0);
    assign rx_full  = (rx_count == CW'(DEPTH));

    assign tx_wr = tx_valid && tx_ready;
    assign tx_rd = pop && pndng;
    assign rx_rd = rx_ready && rx_valid;

    assign id_ok = (D_push[PCKG_SZ-1 -: 8] == DEV_ID) ||
                   (D_push[PCKG_SZ-1 -: 8] == BCAST);
    // A full RX FIFO still accepts a push when a read frees a slot this cycle.
    assign rx_wr = push && id_ok && (!rx_full || rx_rd);

    bus_device_port_fifo #(.W(PCKG_SZ), .DEPTH(DEPTH), .CW(CW)) u_tx (
        .clk   (clk),
        .reset (reset),
        .wr    (tx_wr),
        .wdata (tx_data),
        .rd    (tx_rd),
        .head  (D_pop),
        .count (tx_count)
    );

    bus_device_port_fifo #(.W(PCKG_SZ), .DEPTH(DEPTH), .CW(CW)) u_rx (
        .clk   (clk),
        .reset (reset),
        .wr    (rx_wr),
        .wdata (D_push),
        .rd    (rx_rd),
        .head  (rx_data),
        .count (rx_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_overflow   <= 1'b0;
            rx_misroute   <= 1'b0;
            pop_underflow <= 1'b0;
        end else begin
            if (push && !id_ok)                     rx_misroute   <= 1'b1;
            if (push && id_ok && rx_full && !rx_rd) rx_overflow   <= 1'b1;
            if (pop && !pndng)                      pop_underflow <= 1'b1;
        end
    end
endmodule
